i2c_ball_master: RTL and testbench
==================================

Name: i2c_ball_master

Overview:
I2C master (initiator) that transmits the local ball state to the peer board's I2C slave register file. It is the sending end of the link whose receiving end is the board's I2C slave: reg0 y0, reg1 y1, reg2 Y speed, reg3 gravity, reg4 ball speed. The game controller pulses send_trigger when the ball leaves the screen edge. The block then performs one write burst: START, address+W, register pointer 0x00, five data bytes, STOP.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
I2C_FREQ, 100_000, SCL frequency in Hz; quarter-period QTR = CLK_FREQ/(4*I2C_FREQ) clocks
SLAVE_ADDR, 7'h52, 7-bit address of the peer slave
NUM_BYTES, 5, data bytes per burst, after the pointer byte

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
send_trigger  input  1  one-clock request pulse
y0  input  8  ball entry y, sent to reg0
y1  input  8  ball secondary y, sent to reg1
y_speed  input  8  vertical speed, sent to reg2
gravity  input  8  gravity term, sent to reg3
ball_speed  input  8  horizontal speed, sent to reg4
SCL  output  1  I2C clock, push-pull, idles high
SDA  inout  1  I2C data, open-drain (drive 0 or 'z)
is_transfer  output  1  high from accepted trigger until STOP completes
done  output  1  one-clock pulse when STOP completes
ack_error  output  1  sticky NACK flag, cleared on next accepted trigger

Behaviour:
- Reset (async) forces: SCL=1, SDA released, is_transfer=0, done=0, ack_error=0, state IDLE, tick counter 0. Reset mid-burst abandons the burst; no STOP is generated.
- Tick generator: counter runs only while not IDLE. It issues qtick every QTR clocks. All bus changes occur on qtick.
- send_trigger in IDLE:
  - Snapshot the 5 data inputs into a byte array and clear ack_error.
  - Set is_transfer on the next edge.
  - A trigger while is_transfer=1 is ignored, not queued.
- FSM states: IDLE, START, SEND_BIT, ACK, STOP, DONE.
- START (4 quarters):
  - q0: SDA released, SCL high.
  - q1: SDA low.
  - q2–q3: SCL low.
- SEND_BIT, one bit per 4 quarters, MSB first:
  - q0: SCL low, SDA set (0 → drive low, 1 → release).
  - q1: SCL low.
  - q2–q3: SCL high.
  - 3-bit bit counter; after bit 0, go to ACK.
- ACK: SDA released. Sample SDA at the end of q2 (SCL high).
  - SDA=0: load the next byte (addr+W → 0x00 → bytes 0..NUM_BYTES-1). After the last byte, go to STOP.
  - SDA=1: set ack_error=1 and go to STOP immediately.
- Byte sequence: {SLAVE_ADDR,1'b0}, 8'h00, y0, y1, y_speed, gravity, ball_speed.
  - Byte index counter width: $clog2(NUM_BYTES+2).
- STOP (4 quarters):
  - q0: SCL low, SDA low.
  - q1: SCL high.
  - q2: SDA released.
  - q3: hold.
- DONE (1 clk): pulse done, clear is_transfer, return to IDLE.
- No clock stretching and no arbitration. SDA is never driven high.
- Latency per burst: START (4 quarters) + 7 bytes × 9 bits × 4 quarters + STOP (4 quarters) = 260 quarters; done follows after one more clock.

Decomposition:
- Package i2c_pkg holds:
  - the state enum typedef;
  - localparam REG_PTR_START = 8'h00;
  - constants I2C_WRITE = 1'b0 and I2C_ACK = 1'b0.
  - The package is shared with the slave.
- Sub-module i2c_qtick_gen: counter with enable producing qtick, parameterised by CLK_FREQ and I2C_FREQ.

Test Plan:
- Bench settings: CLK_FREQ=400, I2C_FREQ=100 (QTR=1). The bench models an open-drain slave with a pull-up.
- Trigger with y0=8'h3C, y1=8'h10, y_speed=8'h05, gravity=8'h02, ball_speed=8'h07, slave ACKs all:
  - bus decodes START, A4, 00, 3C, 10, 05, 02, 07, STOP;
  - done pulses exactly 261 clocks after trigger; ack_error=0.
- Slave NACKs the address byte:
  - STOP follows immediately after the 9th bit; ack_error=1; done pulses; no data bytes appear.
- Second trigger during a burst: ignored; the bus carries exactly one burst.
- Inputs change 10 clocks after trigger: bus still carries the snapshot values.
- Reset asserted mid-byte 3:
  - SCL=1 and SDA released asynchronously; is_transfer=0.
  - A following trigger produces a complete correct burst.
- After a NACK, send a new trigger with all ACKs: ack_error clears to 0 on accept.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the ball-link master and its peer slave.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND_BIT,
        ACK,
        STOP,
        DONE
    } i2c_state_t;

    localparam logic [7:0] REG_PTR_START = 8'h00;
    localparam logic       I2C_WRITE     = 1'b0;
    localparam logic       I2C_ACK       = 1'b0;

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-SCL-period strobe generator; the count is held at zero while disabled.
module i2c_qtick_gen #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int I2C_FREQ = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic qtick
);

    localparam int QTR = CLK_FREQ / (4 * I2C_FREQ);
    localparam int CW  = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0] LAST = CW'(QTR - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign qtick = enable && (count == LAST);

endmodule

// File: rtl/i2c_ball_master.sv
// I2C write-burst master: sends addr+W, register pointer 0x00 and the ball-state
// snapshot to the peer board's slave register file each time the ball leaves the screen.
module i2c_ball_master
    import i2c_pkg::*;
#(
    parameter int         CLK_FREQ   = 100_000_000,
    parameter int         I2C_FREQ   = 100_000,
    parameter logic [6:0] SLAVE_ADDR = 7'h52,
    parameter int         NUM_BYTES  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send_trigger,
    input  logic [7:0] y0,
    input  logic [7:0] y1,
    input  logic [7:0] y_speed,
    input  logic [7:0] gravity,
    input  logic [7:0] ball_speed,
    output logic       SCL,
    inout  wire        SDA,
    output logic       is_transfer,
    output logic       done,
    output logic       ack_error
);

    localparam int SEQ_LEN    = NUM_BYTES + 2;
    localparam int IDX_W      = $clog2(SEQ_LEN);
    localparam int NUM_INPUTS = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

    i2c_state_t       state;
    i2c_state_t       state_next;
    logic             qtick;
    logic             quarter_end;
    logic             accept;
    logic             sda_low;
    logic             cur_bit;
    logic [1:0]       quarter;
    logic [2:0]       bit_cnt;
    logic [IDX_W-1:0] byte_idx;
    logic [7:0]       tx_bytes [SEQ_LEN];
    logic [7:0]       in_bytes [NUM_INPUTS];

    assign in_bytes[0] = y0;
    assign in_bytes[1] = y1;
    assign in_bytes[2] = y_speed;
    assign in_bytes[3] = gravity;
    assign in_bytes[4] = ball_speed;

    i2c_qtick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .I2C_FREQ (I2C_FREQ)
    ) u_qtick (
        .clk    (clk),
        .reset  (reset),
        .enable (state != IDLE),
        .qtick  (qtick)
    );

    assign accept      = (state == IDLE) && send_trigger;
    assign quarter_end = qtick && (quarter == 2'd3);
    assign cur_bit     = tx_bytes[byte_idx][bit_cnt];
    assign SDA         = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every phase is four quarters long, so the quarter counter wraps to 0 exactly
    // on each state change and bit_cnt wraps from 0 back to 7 for the next byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quarter   <= '0;
            bit_cnt   <= 3'd7;
            byte_idx  <= '0;
            ack_error <= 1'b0;
            for (int i = 0; i < SEQ_LEN; i++) begin
                tx_bytes[i] <= '0;
            end
        end else if (accept) begin
            quarter     <= '0;
            bit_cnt     <= 3'd7;
            byte_idx    <= '0;
            ack_error   <= 1'b0;
            tx_bytes[0] <= {SLAVE_ADDR, I2C_WRITE};
            tx_bytes[1] <= REG_PTR_START;
            for (int i = 0; i < NUM_BYTES; i++) begin
                tx_bytes[i + 2] <= (i < NUM_INPUTS) ? in_bytes[i % NUM_INPUTS] : 8'h00;
            end
        end else if (qtick) begin
            quarter <= quarter + 2'd1;
            if (state == SEND_BIT && quarter == 2'd3) begin
                bit_cnt <= bit_cnt - 3'd1;
            end
            if (state == ACK && quarter == 2'd2 && SDA != I2C_ACK) begin
                ack_error <= 1'b1;
            end
            if (state == ACK && quarter == 2'd3 && !ack_error && byte_idx != LAST_IDX) begin
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

    // ack_error is cleared on accept, so inside a burst it is set only by the current NACK.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (send_trigger) state_next = START;
            START:    if (quarter_end) state_next = SEND_BIT;
            SEND_BIT: if (quarter_end && bit_cnt == 3'd0) state_next = ACK;
            ACK:      if (quarter_end) state_next = (ack_error || byte_idx == LAST_IDX) ? STOP : SEND_BIT;
            STOP:     if (quarter_end) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        SCL         = 1'b1;
        sda_low     = 1'b0;
        done        = 1'b0;
        is_transfer = 1'b0;
        case (state)
            START: begin
                is_transfer = 1'b1;
                SCL         = !quarter[1];
                sda_low     = (quarter != 2'd0);
            end
            SEND_BIT: begin
                is_transfer = 1'b1;
                SCL         = quarter[1];
                sda_low     = !cur_bit;
            end
            ACK: begin
                is_transfer = 1'b1;
                SCL         = quarter[1];
            end
            STOP: begin
                is_transfer = 1'b1;
                SCL         = (quarter != 2'd0);
                sda_low     = !quarter[1];
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                SCL = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_ball_master.sv
// Directed bench for i2c_ball_master with an open-drain slave model, pull-up and bus decoder.
module tb_i2c_ball_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       send_trigger;
    logic [7:0] y0, y1, y_speed, gravity, ball_speed;
    wire        scl;
    wire        sda_bus;
    wire        is_transfer;
    wire        done;
    wire        ack_error;

    logic       slave_pull = 1'b0;
    int         nack_at = -1;

    int         total = 0;
    int         passed = 0;

    int         start_count = 0;
    int         stop_count = 0;
    int         dec_bits = 0;
    int         dec_byte_num = 0;
    logic [7:0] dec_shift = 8'h00;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       cur_scl;
    logic       cur_sda;
    logic [7:0] bus_bytes [$];
    logic       bus_acks [$];

    assign sda_bus = slave_pull ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_ball_master #(
        .CLK_FREQ   (400),
        .I2C_FREQ   (100),
        .SLAVE_ADDR (7'h52),
        .NUM_BYTES  (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .send_trigger (send_trigger),
        .y0           (y0),
        .y1           (y1),
        .y_speed      (y_speed),
        .gravity      (gravity),
        .ball_speed   (ball_speed),
        .SCL          (scl),
        .SDA          (sda_bus),
        .is_transfer  (is_transfer),
        .done         (done),
        .ack_error    (ack_error)
    );

    // Slave model and bus decoder: START/STOP detection, bits on SCL rise, ACK driven after the 8th fall.
    always @(negedge clk) begin
        if (reset) begin
            dec_bits   = 0;
            slave_pull = 1'b0;
            prev_scl   = 1'b1;
            prev_sda   = 1'b1;
        end else begin
            cur_scl = scl;
            cur_sda = sda_bus;
            if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
                start_count++;
                dec_bits     = 0;
                dec_byte_num = 0;
            end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
                stop_count++;
            end else if (!prev_scl && cur_scl) begin
                if (dec_bits < 8) begin
                    dec_shift = {dec_shift[6:0], cur_sda};
                    dec_bits++;
                end else begin
                    bus_bytes.push_back(dec_shift);
                    bus_acks.push_back(cur_sda);
                    dec_byte_num++;
                    dec_bits = 0;
                end
            end else if (prev_scl && !cur_scl) begin
                slave_pull = (dec_bits == 8) && (dec_byte_num != nack_at);
            end
            prev_scl = cur_scl;
            prev_sda = cur_sda;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Call right after a negedge so the trigger is stable before the next posedge.
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                  input logic [7:0] d, input logic [7:0] e);
        y0           = a;
        y1           = b;
        y_speed      = c;
        gravity      = d;
        ball_speed   = e;
        send_trigger = 1'b1;
    endtask

    task automatic run_burst(input int change_at, input int retrig_at,
                             output int done_at, output logic xfer1, output logic ackerr1);
        done_at = -1;
        xfer1   = 1'b0;
        ackerr1 = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) begin
                send_trigger = 1'b0;
                xfer1        = is_transfer;
                ackerr1      = ack_error;
            end
            if (n == change_at) begin
                y0 = 8'hEE; y1 = 8'hDD; y_speed = 8'hCC; gravity = 8'hBB; ball_speed = 8'hAA;
            end
            if (n == retrig_at) send_trigger = 1'b1;
            if (n == retrig_at + 1) send_trigger = 1'b0;
            if (done) begin
                done_at = n;
                break;
            end
        end
    endtask

    task automatic check_burst(input string tag, input int base, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d, input logic [7:0] e);
        logic [7:0] exp_bytes [7];
        logic       ack_any;
        exp_bytes = '{8'hA4, 8'h00, a, b, c, d, e};
        ack_any   = 1'b0;
        check_output({tag, "_count"}, bus_bytes.size() - base, 7);
        for (int k = 0; k < 7; k++) begin
            if (base + k < bus_bytes.size()) begin
                check_output($sformatf("%s_byte%0d", tag, k), {24'h0, bus_bytes[base + k]}, {24'h0, exp_bytes[k]});
                ack_any = ack_any | bus_acks[base + k];
            end
        end
        check_output({tag, "_acks"}, ack_any, 0);
    endtask

    task automatic full_burst(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input logic [7:0] e, input int change_at, input int retrig_at);
        int   base, sbase, pbase, done_at;
        logic xfer1, ackerr1;
        base  = bus_bytes.size();
        sbase = start_count;
        pbase = stop_count;
        apply_stimulus(a, b, c, d, e);
        run_burst(change_at, retrig_at, done_at, xfer1, ackerr1);
        check_output({tag, "_done_at"}, done_at, 261);
        check_output({tag, "_xfer_after_accept"}, xfer1, 1);
        check_output({tag, "_ackerr_on_accept"}, ackerr1, 0);
        check_output({tag, "_xfer_in_done"}, is_transfer, 0);
        check_output({tag, "_ack_error"}, ack_error, 0);
        check_output({tag, "_starts"}, start_count - sbase, 1);
        check_output({tag, "_stops"}, stop_count - pbase, 1);
        check_burst(tag, base, a, b, c, d, e);
        @(negedge clk);
        check_output({tag, "_done_single"}, done, 0);
    endtask

    initial begin
        int   base, sbase, pbase, done_at;
        logic xfer1, ackerr1;

        reset = 1'b1; send_trigger = 1'b0;
        y0 = 8'h00; y1 = 8'h00; y_speed = 8'h00; gravity = 8'h00; ball_speed = 8'h00;
        repeat (3) @(negedge clk);
        check_output("rst_scl", scl, 1);
        check_output("rst_sda", sda_bus, 1);
        check_output("rst_xfer", is_transfer, 0);
        check_output("rst_done", done, 0);
        check_output("rst_ackerr", ack_error, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] basic burst");
        full_burst("basic", 8'h3C, 8'h10, 8'h05, 8'h02, 8'h07, 0, -10);

        $display("[TB] snapshot and ignored retrigger");
        sbase = start_count;
        full_burst("snap", 8'h81, 8'hFF, 8'h00, 8'h5A, 8'hC3, 10, 50);
        repeat (300) @(negedge clk);
        check_output("retrig_not_queued", start_count - sbase, 1);
        check_output("retrig_idle", is_transfer, 0);

        $display("[TB] address NACK");
        nack_at = 0;
        base  = bus_bytes.size();
        pbase = stop_count;
        apply_stimulus(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        run_burst(0, -10, done_at, xfer1, ackerr1);
        check_output("nack_done_at", done_at, 45);
        check_output("nack_ack_error", ack_error, 1);
        check_output("nack_bytes", bus_bytes.size() - base, 1);
        if (bus_bytes.size() > base) begin
            check_output("nack_addr", {24'h0, bus_bytes[base]}, 32'hA4);
            check_output("nack_ackbit", bus_acks[base], 1);
        end
        check_output("nack_stops", stop_count - pbase, 1);
        repeat (20) @(negedge clk);
        check_output("nack_sticky", ack_error, 1);
        nack_at = -1;

        $display("[TB] recovery after NACK");
        full_burst("recover", 8'h01, 8'h80, 8'h7F, 8'hFE, 8'h55, 0, -10);

        $display("[TB] reset mid byte 3");
        apply_stimulus(8'h3C, 8'h00, 8'h05, 8'h02, 8'h07);
        for (int n = 1; n <= 130; n++) begin
            @(negedge clk);
            if (n == 1) send_trigger = 1'b0;
        end
        check_output("mid_xfer_before", is_transfer, 1);
        #1 reset = 1'b1;
        #1;
        check_output("mid_rst_scl", scl, 1);
        check_output("mid_rst_sda", sda_bus, 1);
        check_output("mid_rst_xfer", is_transfer, 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        full_burst("after_rst", 8'h9A, 8'h42, 8'h03, 8'h01, 8'h0F, 0, -10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
